mac_requant_accumulator: RTL and testbench

- Downstream consumer of the 4-lane int8 MAC unit.
- Accumulates a configurable number of consecutive 32-bit signed MAC partial sums into one dot-product result.
- Requantizes each result to int8: bias add, rounding arithmetic shift, optional ReLU, clamp.
- Buffers results in a small FIFO behind a valid/ready output, because the MAC itself has no backpressure.

---
 rtl/mac_requant_accumulator.sv | 178 +++++++++++++++++
 tb/tb_mac_requant_accumulator.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_requant_accumulator.sv
// Accumulates MAC partial sums into dot products, requantizes each to int8
// and buffers the results in a show-ahead FIFO behind a valid/ready output.
module mac_requant_accumulator #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_valid_i,
  input  logic [CNT_W-1:0] cfg_len_i,
  input  logic [CNT_W-1:0] cfg_groups_i,
  input  logic [XLEN-1:0]  cfg_bias_i,
  input  logic [4:0]       cfg_shift_i,
  input  logic             cfg_relu_i,
  input  logic             mac_valid_i,
  input  logic [XLEN-1:0]  mac_result_i,
  output logic             acc_ready_o,
  output logic             out_valid_o,
  output logic [7:0]       out_data_o,
  input  logic             out_ready_i,
  output logic             busy_o,
  output logic             err_o
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic signed [XLEN:0] SAT_HI = (XLEN+1)'(127);
  localparam logic signed [XLEN:0] SAT_LO = (XLEN+1)'(-128);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d, groups_q, groups_d;
  logic [CNT_W-1:0] len_cnt_q, len_cnt_d, group_cnt_q, group_cnt_d;
  logic [XLEN-1:0]  bias_q, bias_d, acc_q, acc_d, post_total_q, post_total_d;
  logic [4:0]       shift_q, shift_d;
  logic             relu_q, relu_d, post_valid_q, post_valid_d, err_q, err_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;

  logic [XLEN-1:0]        acc_sum, s_sat;
  logic signed [XLEN:0]   s_ext, r_val;
  logic [XLEN:0]          rnd_add;
  logic [7:0]             q8;
  logic                   full, push, pop, push_ok, drop;

  function automatic logic [XLEN-1:0] sat_add(input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    logic [XLEN:0] s;
    s = {a[XLEN-1], a} + {b[XLEN-1], b};
    if (s[XLEN] != s[XLEN-1])
      sat_add = s[XLEN] ? {1'b1, {(XLEN-1){1'b0}}} : {1'b0, {(XLEN-1){1'b1}}};
    else
      sat_add = s[XLEN-1:0];
  endfunction

  // Post stage: bias, round-half-up shift in XLEN+1 bits, ReLU, int8 clamp.
  always_comb begin
    s_sat   = sat_add(post_total_q, bias_q);
    s_ext   = $signed({s_sat[XLEN-1], s_sat});
    rnd_add = (shift_q == '0) ? '0 : ((XLEN+1)'(1) << (shift_q - 5'd1));
    r_val   = (s_ext + $signed(rnd_add)) >>> shift_q;
    if (relu_q && r_val[XLEN]) r_val = '0;
    if (r_val > SAT_HI)      q8 = 8'h7f;
    else if (r_val < SAT_LO) q8 = 8'h80;
    else                     q8 = r_val[7:0];
  end

  always_comb begin
    full    = (count_q == (AW+1)'(FIFO_DEPTH));
    push    = post_valid_q;
    pop     = out_valid_o && out_ready_i;
    push_ok = push && (!full || pop);
    drop    = push && full && !pop;
    mem_d   = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = q8;
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop);
  end

  always_comb begin
    acc_sum      = sat_add(acc_q, mac_result_i);
    state_d      = state_q;
    len_d        = len_q;
    groups_d     = groups_q;
    bias_d       = bias_q;
    shift_d      = shift_q;
    relu_d       = relu_q;
    acc_d        = acc_q;
    len_cnt_d    = len_cnt_q;
    group_cnt_d  = group_cnt_q;
    post_valid_d = 1'b0;
    post_total_d = post_total_q;
    err_d        = err_q;
    case (state_q)
      S_IDLE: if (cfg_valid_i) begin
        len_d       = (cfg_len_i == '0) ? CNT_W'(1) : cfg_len_i;
        groups_d    = (cfg_groups_i == '0) ? CNT_W'(1) : cfg_groups_i;
        bias_d      = cfg_bias_i;
        shift_d     = cfg_shift_i;
        relu_d      = cfg_relu_i;
        acc_d       = '0;
        len_cnt_d   = '0;
        group_cnt_d = '0;
        err_d       = 1'b0;
        state_d     = S_ACCUM;
      end
      S_ACCUM: if (mac_valid_i) begin
        if (len_cnt_q == len_q - CNT_W'(1)) begin
          post_valid_d = 1'b1;
          post_total_d = acc_sum;
          acc_d        = '0;
          len_cnt_d    = '0;
          group_cnt_d  = group_cnt_q + CNT_W'(1);
          if (group_cnt_q == groups_q - CNT_W'(1)) state_d = S_DRAIN;
        end else begin
          acc_d     = acc_sum;
          len_cnt_d = len_cnt_q + CNT_W'(1);
        end
      end
      S_DRAIN: if (!post_valid_q && count_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Error sources override a same-cycle config clear so nothing is lost.
    if (mac_valid_i && state_q != S_ACCUM) err_d = 1'b1;
    if (drop) err_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      groups_q     <= '0;
      bias_q       <= '0;
      shift_q      <= '0;
      relu_q       <= 1'b0;
      acc_q        <= '0;
      len_cnt_q    <= '0;
      group_cnt_q  <= '0;
      post_valid_q <= 1'b0;
      post_total_q <= '0;
      err_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      groups_q     <= groups_d;
      bias_q       <= bias_d;
      shift_q      <= shift_d;
      relu_q       <= relu_d;
      acc_q        <= acc_d;
      len_cnt_q    <= len_cnt_d;
      group_cnt_q  <= group_cnt_d;
      post_valid_q <= post_valid_d;
      post_total_q <= post_total_d;
      err_q        <= err_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      mem_q        <= mem_d;
    end
  end

  // Two free slots beyond the in-flight result cover a length-1 group already in the MAC.
  assign acc_ready_o = (state_q == S_ACCUM) &&
                       (((AW+1)'(FIFO_DEPTH) - count_q) >= ((AW+1)'(2) + (AW+1)'(post_valid_q)));
  assign out_valid_o = (count_q != '0);
  assign out_data_o  = mem_q[rd_ptr_q];
  assign busy_o      = (state_q != S_IDLE);
  assign err_o       = err_q;

endmodule

// File: tb/tb_mac_requant_accumulator.sv
// Randomized bench for mac_requant_accumulator: an arithmetic model predicts the
// int8 result stream, a negedge process compares every popped result.
module tb_mac_requant_accumulator;
  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        cfg_valid_i = 1'b0;
  logic [15:0] cfg_len_i = '0, cfg_groups_i = '0;
  logic [31:0] cfg_bias_i = '0;
  logic [4:0]  cfg_shift_i = '0;
  logic        cfg_relu_i = 1'b0;
  logic        mac_valid_i = 1'b0;
  logic [31:0] mac_result_i = '0;
  logic        acc_ready_o, out_valid_o, out_ready_i = 1'b0, busy_o, err_o;
  logic [7:0]  out_data_o;

  mac_requant_accumulator #(.XLEN(32), .FIFO_DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cfg_valid_i(cfg_valid_i), .cfg_len_i(cfg_len_i),
    .cfg_groups_i(cfg_groups_i), .cfg_bias_i(cfg_bias_i), .cfg_shift_i(cfg_shift_i),
    .cfg_relu_i(cfg_relu_i), .mac_valid_i(mac_valid_i), .mac_result_i(mac_result_i),
    .acc_ready_o(acc_ready_o), .out_valid_o(out_valid_o), .out_data_o(out_data_o),
    .out_ready_i(out_ready_i), .busy_o(busy_o), .err_o(err_o));

  always #5 clk_i = ~clk_i;

  int     total = 0, bad = 0, cyc = 0;
  int     exp_q[$];
  bit     rec_en = 1'b0;
  int     pop_cyc[$], rec_data[$];

  longint m_acc, m_bias;
  int     m_len, m_groups, m_cnt, m_grp, m_shift;
  bit     m_relu, m_accum = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint sat32(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  function automatic int model_rq(input longint t);
    longint s, r;
    s = sat32(t + m_bias);
    if (m_shift > 0) r = (s + (longint'(1) << (m_shift - 1))) >>> m_shift;
    else r = s;
    if (m_relu && r < 0) r = 0;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return int'(r);
  endfunction

  always @(negedge clk_i) begin
    cyc++;
    if (rst_i && out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) chk("stream_unexpected", $signed(out_data_o), -9999);
      else chk("stream", $signed(out_data_o), exp_q.pop_front());
      if (rec_en) begin
        pop_cyc.push_back(cyc);
        rec_data.push_back(int'($signed(out_data_o)));
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic config_job(input int len, input int groups, input int bias,
                            input int shift, input bit relu);
    cfg_valid_i = 1'b1; cfg_len_i = 16'(len); cfg_groups_i = 16'(groups);
    cfg_bias_i = bias; cfg_shift_i = 5'(shift); cfg_relu_i = relu;
    m_len = (len % 65536 == 0) ? 1 : len % 65536;
    m_groups = (groups % 65536 == 0) ? 1 : groups % 65536;
    m_bias = longint'(bias); m_shift = shift; m_relu = relu;
    m_acc = 0; m_cnt = 0; m_grp = 0; m_accum = 1'b1;
    tick();
    cfg_valid_i = 1'b0;
  endtask

  // One partial sum; the model drops a result only if the FIFO already holds DEPTH.
  task automatic issue(input int v);
    mac_valid_i = 1'b1; mac_result_i = v;
    if (m_accum) begin
      m_acc = sat32(m_acc + longint'(v));
      m_cnt++;
      if (m_cnt == m_len) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(model_rq(m_acc));
        m_acc = 0; m_cnt = 0; m_grp++;
        if (m_grp == m_groups) m_accum = 1'b0;
      end
    end
    tick();
    mac_valid_i = 1'b0;
  endtask

  task automatic wait_ready();
    int k;
    for (k = 0; k < 100 && !acc_ready_o; k++) tick();
    if (!acc_ready_o) chk("ready_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200; k++) begin
      out_ready_i = 1'b1;
      if (!busy_o && exp_q.size() == 0) break;
      tick();
    end
    chk("idle_busy", busy_o, 0);
    chk("idle_queue", exp_q.size(), 0);
    out_ready_i = 1'b0;
  endtask

  task automatic expect_out(input string name, input int lit);
    for (int k = 0; k < 30 && !out_valid_o; k++) @(negedge clk_i);
    chk({name, "_valid"}, out_valid_o, 1);
    chk({name, "_data"}, $signed(out_data_o), lit);
    chk({name, "_model"}, (exp_q.size() > 0) ? exp_q[0] : -9999, lit);
    tick();
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
  endtask

  function automatic int rand_val();
    case ($urandom_range(0, 3))
      0: return int'($urandom());
      1: return $urandom_range(0, 4000) - 2000;
      default: return $urandom_range(0, 400) - 200;
    endcase
  endfunction

  initial begin
    int n;
    bit saw_low;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_ready", acc_ready_o, 0);
    chk("rst_valid", out_valid_o, 0);
    chk("rst_data", out_data_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    @(negedge clk_i) rst_i = 1'b1;
    tick();

    // Partial sum while IDLE sets the sticky error; a new config clears it.
    mac_valid_i = 1'b1; mac_result_i = 5;
    tick();
    mac_valid_i = 1'b0;
    chk("idle_mac_err", err_o, 1);

    config_job(3, 1, 0, 0, 0);
    chk("cfg_clears_err", err_o, 0);
    chk("accum_busy", busy_o, 1);
    issue(10); issue(-4); issue(20);
    @(negedge clk_i) chk("lat_t1", out_valid_o, 0);
    @(negedge clk_i) chk("lat_t2", out_valid_o, 1);
    expect_out("single", 26);
    wait_idle();

    config_job(1, 2, 5, 2, 0);
    issue(10);  expect_out("round_pos", 4);
    issue(-20); expect_out("round_neg", -4);
    wait_idle();
    config_job(1, 1, 5, 2, 1);
    issue(-20); expect_out("relu", 0);
    wait_idle();

    config_job(2, 1, 0, 0, 0);
    issue(32'h7FFFFFF0); issue(32'h00000100); expect_out("sat_hi", 127);
    wait_idle();
    config_job(1, 1, 0, 0, 0);
    issue(-1000); expect_out("sat_lo", -128);
    wait_idle();
    config_job(3, 1, 0, 20, 0);
    issue(32'h7FFFFFF0); issue(32'h00FFFFF0); issue(-32'sh7F000000);
    expect_out("sat_acc", 16);
    wait_idle();

    config_job(1, 4, 0, 0, 0);
    out_ready_i = 1'b1; rec_en = 1'b1;
    issue(1); issue(2); issue(3); issue(4);
    wait_idle();
    rec_en = 1'b0;
    chk("b2b_count", pop_cyc.size(), 4);
    for (int i = 0; i < 4 && i < pop_cyc.size(); i++) begin
      chk("b2b_spacing", pop_cyc[i] - pop_cyc[0], i);
      chk("b2b_data", rec_data[i], i + 1);
    end
    chk("b2b_err", err_o, 0);

    config_job(1, 6, $urandom_range(0, 40) - 20, $urandom_range(0, 3), 1'($urandom()));
    out_ready_i = 1'b0; n = 0; saw_low = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (acc_ready_o) begin issue(rand_val()); n++; end
      else begin saw_low = 1'b1; tick(); end
    end
    chk("bp_gated_issues", n, 3);
    chk("bp_saw_low", saw_low, 1);
    chk("bp_ready_low", acc_ready_o, 0);
    chk("bp_err_none", err_o, 0);
    issue(rand_val()); repeat (3) tick();
    chk("bp_full_no_err", err_o, 0);
    issue(rand_val()); repeat (3) tick();
    chk("bp_drop_err", err_o, 1);
    out_ready_i = 1'b1;
    repeat (6) tick();
    out_ready_i = 1'b0;
    chk("bp_drained", exp_q.size(), 0);
    wait_ready(); issue(rand_val());
    wait_idle();
    chk("bp_err_sticky", err_o, 1);

    config_job(1, 5, 0, 0, 0);
    chk("mid_cfg_err_clr", err_o, 0);
    issue(7); issue(-3); repeat (3) tick();
    chk("mid_two_held", out_valid_o, 1);
    #2 rst_i = 1'b0;
    #1;
    chk("mid_ready", acc_ready_o, 0);
    chk("mid_valid", out_valid_o, 0);
    chk("mid_data", out_data_o, 0);
    chk("mid_busy", busy_o, 0);
    chk("mid_err", err_o, 0);
    exp_q.delete(); m_accum = 1'b0;
    @(negedge clk_i) rst_i = 1'b1;
    tick();
    config_job(2, 2, $urandom_range(0, 100) - 50, $urandom_range(0, 4), 0);
    repeat (4) begin wait_ready(); issue(rand_val()); end
    wait_idle();

    // Random jobs: gated upstream, random consumer stalls, ignored mid-job configs.
    for (int j = 0; j < 8; j++) begin
      config_job($urandom_range(0, 4), $urandom_range(0, 5),
                 ($urandom_range(0, 1) != 0) ? int'($urandom()) : $urandom_range(0, 200) - 100,
                 ($urandom_range(0, 4) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 6),
                 1'($urandom()));
      for (int k = 0; k < 400 && m_accum; k++) begin
        out_ready_i = ($urandom_range(0, 3) != 0);
        cfg_valid_i = ($urandom_range(0, 7) == 0);
        cfg_len_i = 16'($urandom()); cfg_shift_i = 5'($urandom());
        if (acc_ready_o && $urandom_range(0, 3) != 0) issue(rand_val());
        else tick();
      end
      cfg_valid_i = 1'b0;
      chk("rand_job_done", m_accum, 0);
      wait_idle();
    end
    chk("rand_err", err_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
